// File: rtl/dds_write_scheduler.sv
// Round-robin arbiter sharing one AD9910 serial register writer among NREQ requesters, with optional IO_UPDATE strobe.
// Latency: grant registers ready one edge after req is seen; ack comes one edge after DONE (8*L+3 cycles for an L-byte frame).
// Backpressure: no grant while the writer reports busy; requesters hold req/data until their one-cycle ack.
module dds_write_scheduler #(
  parameter int NREQ          = 4,
  parameter int MAXLENGTH     = 9,
  parameter int UPDATE_WIDTH  = 4,
  parameter int ISSUE_TIMEOUT = 15,
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int DW = MAXLENGTH * 8
) (
  input  logic               DDS_clock,
  input  logic               resetbar,
  input  logic [NREQ-1:0]    req,
  input  logic [4*NREQ-1:0]  req_length,
  input  logic [DW*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]    req_update,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic [3:0]         dataLength,
  output logic [DW-1:0]      registerData,
  output logic               registerDataReady,
  input  logic               busy,
  output logic               io_update,
  output logic               sched_busy,
  output logic [GW-1:0]      grant_id
);

  localparam int TW = $clog2(ISSUE_TIMEOUT + 1);
  localparam logic [3:0]    MAXLEN4 = 4'(MAXLENGTH);
  localparam logic [3:0]    UPD4    = 4'(UPDATE_WIDTH);
  localparam logic [TW-1:0] TO_LAST = TW'(ISSUE_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(ISSUE_TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_DONE} state_t;

  state_t          state, state_n;
  logic [GW-1:0]   rr_ptr, rr_n;
  logic [GW-1:0]   gid_n;
  logic [3:0]      len_n;
  logic [DW-1:0]   data_n;
  logic            rdy_n;
  logic            upd_lat, upd_lat_n;
  logic            err_flag, err_flag_n;
  logic [NREQ-1:0] ack_n;
  logic            err_n;
  logic            io_n;
  logic [3:0]      upd_cnt, upd_cnt_n;
  logic [TW-1:0]   to_cnt, to_cnt_n;

  logic            win_vld;
  logic [GW-1:0]   win_idx;
  logic [GW-1:0]   cand;
  logic [3:0]      win_len;
  logic [DW-1:0]   win_data;
  logic            len_ok;

  // Round-robin pick: scan downward in offset so the lowest offset from rr_ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = GW'((int'(rr_ptr) + k) % NREQ);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_len    = req_length[int'(win_idx)*4 +: 4];
  assign win_data   = req_data[int'(win_idx)*DW +: DW];
  assign len_ok     = (win_len != 4'd0) && (win_len <= MAXLEN4);
  assign sched_busy = (state != S_IDLE);

  // Next-state and next-output logic; everything holds unless a state says otherwise.
  always_comb begin
    state_n    = state;
    rr_n       = rr_ptr;
    gid_n      = grant_id;
    len_n      = dataLength;
    data_n     = registerData;
    rdy_n      = registerDataReady;
    upd_lat_n  = upd_lat;
    err_flag_n = err_flag;
    ack_n      = '0;
    err_n      = 1'b0;
    io_n       = io_update;
    upd_cnt_n  = upd_cnt;
    to_cnt_n   = to_cnt;
    case (state)
      S_IDLE: begin
        // Writer still busy (e.g. finishing a frame after reset) blocks any grant.
        if (!busy && win_vld) begin
          gid_n     = win_idx;
          len_n     = win_len;
          data_n    = win_data;
          upd_lat_n = req_update[win_idx];
          rr_n      = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
          to_cnt_n  = '0;
          if (len_ok) begin
            rdy_n      = 1'b1;
            err_flag_n = 1'b0;
            state_n    = S_ISSUE;
          end else begin
            err_flag_n = 1'b1;
            state_n    = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (busy) begin
          rdy_n   = 1'b0;
          state_n = S_WAIT;
        end else if (to_cnt >= TO_LAST) begin
          rdy_n      = 1'b0;
          err_flag_n = 1'b1;
          state_n    = S_DONE;
        end else if (to_cnt != TO_MAX) begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        // Data stays on the bus until the writer lets go of busy.
        if (!busy) begin
          if (upd_lat) begin
            io_n      = 1'b1;
            upd_cnt_n = UPD4;
            state_n   = S_UPDATE;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_UPDATE: begin
        if (upd_cnt <= 4'd1) begin
          io_n      = 1'b0;
          upd_cnt_n = 4'd0;
          state_n   = S_DONE;
        end else begin
          upd_cnt_n = upd_cnt - 4'd1;
        end
      end
      S_DONE: begin
        ack_n[grant_id] = 1'b1;
        err_n           = err_flag;
        err_flag_n      = 1'b0;
        state_n         = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; reset drops every output at once, mid-frame or not.
  always_ff @(posedge DDS_clock or negedge resetbar) begin
    if (!resetbar) begin
      state             <= S_IDLE;
      rr_ptr            <= '0;
      grant_id          <= '0;
      dataLength        <= '0;
      registerData      <= '0;
      registerDataReady <= 1'b0;
      upd_lat           <= 1'b0;
      err_flag          <= 1'b0;
      ack               <= '0;
      err               <= 1'b0;
      io_update         <= 1'b0;
      upd_cnt           <= '0;
      to_cnt            <= '0;
    end else begin
      state             <= state_n;
      rr_ptr            <= rr_n;
      grant_id          <= gid_n;
      dataLength        <= len_n;
      registerData      <= data_n;
      registerDataReady <= rdy_n;
      upd_lat           <= upd_lat_n;
      err_flag          <= err_flag_n;
      ack               <= ack_n;
      err               <= err_n;
      io_update         <= io_n;
      upd_cnt           <= upd_cnt_n;
      to_cnt            <= to_cnt_n;
    end
  end

endmodule

// File: tb/tb_dds_write_scheduler.sv
// Bench for dds_write_scheduler: scoreboard of expected completions, serial-writer stub on the falling edge.
// Latency: checks grant-to-ack timing per frame against 8*L+3 (+UPDATE_WIDTH when io_update requested).
// Backpressure: writer stub drives busy; a disabled stub exercises the issue timeout.
module tb_dds_write_scheduler;

  localparam int NREQ          = 4;
  localparam int MAXLENGTH     = 9;
  localparam int UPDATE_WIDTH  = 4;
  localparam int ISSUE_TIMEOUT = 15;
  localparam int DW            = MAXLENGTH * 8;
  localparam int GW            = 2;

  logic                 DDS_clock = 1'b0;
  logic                 resetbar;
  logic [NREQ-1:0]      req;
  logic [4*NREQ-1:0]    req_length;
  logic [DW*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_update;
  logic [NREQ-1:0]      ack;
  logic                 err;
  logic [3:0]           dataLength;
  logic [DW-1:0]        registerData;
  logic                 registerDataReady;
  logic                 busy;
  logic                 io_update;
  logic                 sched_busy;
  logic [GW-1:0]        grant_id;

  dds_write_scheduler #(
    .NREQ(NREQ), .MAXLENGTH(MAXLENGTH), .UPDATE_WIDTH(UPDATE_WIDTH), .ISSUE_TIMEOUT(ISSUE_TIMEOUT)
  ) dut (
    .DDS_clock(DDS_clock), .resetbar(resetbar), .req(req), .req_length(req_length),
    .req_data(req_data), .req_update(req_update), .ack(ack), .err(err),
    .dataLength(dataLength), .registerData(registerData), .registerDataReady(registerDataReady),
    .busy(busy), .io_update(io_update), .sched_busy(sched_busy), .grant_id(grant_id)
  );

  always #5 DDS_clock = ~DDS_clock;

  // kind: 0 = normal frame, 1 = invalid length, 2 = issue timeout
  typedef struct {
    int          id;
    bit          err;
    int          kind;
    int          len;
    logic [71:0] data;
    bit          upd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // writer stub and per-frame observation state
  bit          wr_en;
  bit          wr_latch;
  int          wr_cnt;
  logic [3:0]  wr_len;
  logic [71:0] wr_data;
  int          cyc;
  int          rdy_cnt, io_cnt, io_first, busy_fall, grant_cyc;
  bit          stable_bad, rdy_bad;
  logic [3:0]  last_ack;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_frame();
    rdy_cnt    = 0;
    io_cnt     = 0;
    io_first   = -1;
    stable_bad = 0;
    rdy_bad    = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ack"},        128'(ack), 128'(0));
    check({pfx, "_err"},        128'(err), 128'(0));
    check({pfx, "_len"},        128'(dataLength), 128'(0));
    check({pfx, "_data"},       128'(registerData), 128'(0));
    check({pfx, "_ready"},      128'(registerDataReady), 128'(0));
    check({pfx, "_io_update"},  128'(io_update), 128'(0));
    check({pfx, "_sched_busy"}, 128'(sched_busy), 128'(0));
    check({pfx, "_grant_id"},   128'(grant_id), 128'(0));
  endtask

  task automatic on_ack();
    exp_t e;
    int   lat, base;
    if (sb.size() == 0) begin
      check("unexpected_ack", 128'(ack), 128'(0));
      return;
    end
    e = sb.pop_front();
    check("ack_onehot", 128'(ack), 128'(1 << e.id));
    check("ack_err", 128'(err), 128'(e.err));
    check("grant_id", 128'(grant_id), 128'(e.id));
    if (e.kind == 0) begin
      check("wr_len", 128'(wr_len), 128'(e.len));
      check("wr_data", 128'(wr_data), 128'(e.data));
      check("io_cycles", 128'(io_cnt), 128'(e.upd ? UPDATE_WIDTH : 0));
      check("ready_cycles_1_2", 128'(rdy_cnt >= 1 && rdy_cnt <= 2), 128'(1));
      check("data_stable_in_wait", 128'(stable_bad), 128'(0));
      check("no_ready_in_wait", 128'(rdy_bad), 128'(0));
      if (e.upd) check("io_after_busy_low", 128'(io_first - busy_fall), 128'(1));
      // grant edge to the edge where ack is sampled high
      lat  = cyc - grant_cyc + 1;
      base = 8 * e.len + 3 + (e.upd ? UPDATE_WIDTH : 0);
      check("ack_latency", 128'(lat >= base - 1 && lat <= base + 1), 128'(1));
    end else if (e.kind == 1) begin
      check("invalid_no_ready", 128'(rdy_cnt), 128'(0));
    end else begin
      check("timeout_ready_cycles", 128'(rdy_cnt >= ISSUE_TIMEOUT && rdy_cnt <= ISSUE_TIMEOUT + 1), 128'(1));
      check("timeout_no_io", 128'(io_cnt), 128'(0));
    end
    clear_frame();
  endtask

  // One cycle: observe outputs at the falling edge, then step the writer stub, then drop acked requests.
  task automatic tick();
    @(negedge DDS_clock);
    cyc++;
    if (registerDataReady) begin
      if (rdy_cnt == 0) grant_cyc = cyc;
      rdy_cnt++;
      if (busy) rdy_bad = 1;
    end
    if (io_update) begin
      if (io_cnt == 0) io_first = cyc;
      io_cnt++;
    end
    last_ack = ack;
    if (ack != '0) on_ack();
    if (wr_cnt > 0) begin
      if (wr_latch) begin
        wr_data  = registerData;
        wr_latch = 0;
      end else if (registerData !== wr_data) begin
        stable_bad = 1;
      end
      wr_cnt--;
      if (wr_cnt == 0) begin
        busy      = 1'b0;
        busy_fall = cyc;
      end
    end else if (wr_en && registerDataReady && !busy) begin
      busy       = 1'b1;
      wr_cnt     = 8 * int'(dataLength);
      wr_len     = dataLength;
      wr_latch   = 1;
      stable_bad = 0;
      rdy_bad    = 0;
    end
    req = req & ~ack;
  endtask

  task automatic post(input int id, input int len, input bit upd, input int kind, input logic [71:0] d);
    exp_t e;
    req_length[4*id +: 4] = 4'(len);
    req_data[DW*id +: DW] = d;
    req_update[id]        = upd;
    req[id]               = 1'b1;
    e.id   = id;
    e.len  = len;
    e.upd  = upd;
    e.kind = kind;
    e.err  = (kind != 0);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", 128'(sb.size()), 128'(0));
    sb.delete();
    tick();
  endtask

  task automatic pulse_reset();
    resetbar = 1'b0;
    tick();
    resetbar = 1'b1;
    tick();
  endtask

  function automatic logic [71:0] rnd72();
    return {8'($urandom()), $urandom(), $urandom()};
  endfunction

  initial begin
    int          n, viol;
    logic [71:0] d;
    resetbar   = 1'b0;
    req        = '0;
    req_length = '0;
    req_data   = '0;
    req_update = '0;
    busy       = 1'b0;
    wr_en      = 1;
    wr_latch   = 0;
    wr_cnt     = 0;
    wr_len     = '0;
    wr_data    = '0;
    cyc        = 0;
    busy_fall  = 0;
    grant_cyc  = 0;
    last_ack   = '0;
    clear_frame();
    tick();
    tick();
    check_reset_outputs("reset");
    resetbar = 1'b1;
    tick();

    // single write with IO_UPDATE
    post(0, 5, 1, 0, {8'h0E, 32'hA1B2C3D4, 32'h55000000});
    drain(500);

    // four simultaneous requesters, then requester 0 re-requests immediately
    pulse_reset();
    for (int i = 0; i < NREQ; i++) post(i, 3, 0, 0, rnd72());
    n = 0;
    while (!last_ack[0] && n < 200) begin
      tick();
      n++;
    end
    check("ack0_seen", 128'(last_ack[0]), 128'(1));
    tick();
    post(0, 3, 1, 0, rnd72());
    drain(1000);

    // invalid lengths still advance the round-robin pointer
    pulse_reset();
    post(1, 0, 0, 1, rnd72());
    post(2, 10, 1, 1, rnd72());
    drain(100);
    post(3, 2, 0, 0, rnd72());
    post(0, 2, 1, 0, rnd72());
    drain(500);

    // writer never answers: issue timeout
    wr_en = 0;
    post(3, 4, 1, 2, rnd72());
    drain(100);
    wr_en = 1;
    check("timeout_idle", 128'(sched_busy), 128'(0));
    check("timeout_ready_low", 128'(registerDataReady), 128'(0));

    // asynchronous reset while the writer is mid-frame
    d = rnd72();
    post(2, 6, 1, 0, d);
    n = 0;
    while (!(sched_busy && busy && !registerDataReady) && n < 50) begin
      tick();
      n++;
    end
    check("reached_wait", 128'(sched_busy && busy), 128'(1));
    repeat (5) tick();
    @(posedge DDS_clock);
    #3;
    resetbar = 1'b0;
    #1;
    check_reset_outputs("arst");
    if (sb.size() != 0) void'(sb.pop_front());
    clear_frame();
    tick();
    resetbar = 1'b1;
    viol = 0;
    n    = 0;
    while (busy && n < 200) begin
      tick();
      if (sched_busy || registerDataReady) viol++;
      n++;
    end
    check("no_grant_while_busy", 128'(viol), 128'(0));
    check("writer_finished", 128'(busy), 128'(0));
    post(2, 6, 1, 0, d);
    drain(500);

    // longest frame, no IO_UPDATE
    post(1, 9, 0, 0, rnd72());
    drain(1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
